cflog_writer: RTL and testbench



---
 rtl/cflog_pkg.sv | 31 +++
 rtl/cflog_writer_if.sv | 30 +++
 rtl/cflog_ptr.sv | 41 ++++
 rtl/cflog_writer.sv | 188 ++++++++++++++++++
 tb/tb_cflog_writer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cflog_pkg.sv
// cflog_pkg: shared types and constants for the control-flow log writer.
//   - state_t     : writer FSM states (ST_WR_CNT only with CFLOG_LOOP_COMPRESS_EN)
//   - LOG_MIN_DEF : byte address of log word 0 (shared with boundary_monitor)
//   - LOG_SIZE_DEF: log capacity in 16-bit words (shared with boundary_monitor)
//   - ENTRY_*     : words consumed by one logged event
// Optional feature macro: CFLOG_LOOP_COMPRESS_EN (loop compression).
package cflog_pkg;

  localparam logic [15:0] LOG_MIN_DEF  = 16'h01B0;
  localparam logic [15:0] LOG_SIZE_DEF = 16'h0080;

  localparam int unsigned ENTRY_WORDS_BASE = 2;  // src + dst
  localparam int unsigned ENTRY_WORDS_CMP  = 3;  // count + src + dst

`ifdef CFLOG_LOOP_COMPRESS_EN
  localparam int unsigned ENTRY_SZ = ENTRY_WORDS_CMP;
`else
  localparam int unsigned ENTRY_SZ = ENTRY_WORDS_BASE;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SRC,
    ST_WR_DST,
`ifdef CFLOG_LOOP_COMPRESS_EN
    ST_WR_CNT,
`endif
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/cflog_writer_if.sv
// cflog_writer_if: bundles the trace input, the TCB flush handshake and the
// dedicated log write port of the control-flow log writer.
//   master : the log writer (consumes trace/flush inputs, drives log port)
//   slave  : the environment (CPU trace source, TCB, log memory)
interface cflog_writer_if;
  logic        branch_valid;
  logic [15:0] branch_src;
  logic [15:0] branch_dst;
  logic        flush_now;
  logic        flush_ack;
  logic        log_wr_en;
  logic [15:0] log_wr_addr;
  logic [15:0] log_wr_data;
  logic [15:0] log_ptr;
  logic        flush_req;
  logic        cpu_stall;
  logic        overflow;

  modport master (
    input  branch_valid, branch_src, branch_dst, flush_now, flush_ack,
    output log_wr_en, log_wr_addr, log_wr_data, log_ptr,
           flush_req, cpu_stall, overflow
  );

  modport slave (
    output branch_valid, branch_src, branch_dst, flush_now, flush_ack,
    input  log_wr_en, log_wr_addr, log_wr_data, log_ptr,
           flush_req, cpu_stall, overflow
  );
endinterface

// File: rtl/cflog_ptr.sv
// cflog_ptr: log pointer (words in log) with increment/clear, plus byte
// address generation and the free-space test used at the end of an entry.
//   clk, reset : clock, synchronous active-high reset
//   inc, clr   : advance pointer by one word / return it to zero (clr wins)
//   ptr        : words currently in the log
//   addr_cur   : byte address of word ptr
//   addr_inc   : byte address of word ptr+1 (the next write during an entry)
//   free_low   : after this increment, fewer than ENTRY words remain
module cflog_ptr
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_MIN  = LOG_MIN_DEF,
  parameter logic [15:0] LOG_SIZE = LOG_SIZE_DEF,
  parameter int unsigned ENTRY    = ENTRY_SZ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] ptr,
  output logic [15:0] addr_cur,
  output logic [15:0] addr_inc,
  output logic        free_low
);

  logic [15:0] ptr_inc;
  assign ptr_inc = ptr + 16'd1;

  always_ff @(posedge clk) begin
    if (reset)    ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr_inc;
  end

  // Word index to byte address; 16-bit wrap is intended.
  assign addr_cur = LOG_MIN + {ptr[14:0], 1'b0};
  assign addr_inc = LOG_MIN + {ptr_inc[14:0], 1'b0};

  assign free_low = (LOG_SIZE - ptr_inc) < 16'(ENTRY);

endmodule

// File: rtl/cflog_writer.sv
// cflog_writer: captures branch src/dst pairs and writes them sequentially
// into the LOG region via a dedicated write port; stalls the CPU and hands
// the log to the TCB (flush_req/flush_ack) when full or on flush_now.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cflog_writer_if.master (trace in, flush handshake, log port)
// Optional feature macro: CFLOG_LOOP_COMPRESS_EN -- identical consecutive
// pairs are counted instead of written; the count word is emitted before
// the next differing pair or before a flush.
module cflog_writer
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_MIN  = LOG_MIN_DEF,
  parameter logic [15:0] LOG_SIZE = LOG_SIZE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  cflog_writer_if.master bus
);

  state_t      state;
  logic        wr_en_q, flush_req_q, stall_q, ovf_q;
  logic [15:0] wr_addr_q, wr_data_q;
  logic [15:0] pair_src, pair_dst;  // entry being written / last written pair
  logic        ptr_inc_en, ptr_clr;
  logic [15:0] ptr, addr_cur, addr_inc;
  logic        free_low;

`ifdef CFLOG_LOOP_COMPRESS_EN
  logic        last_vld;
  logic [15:0] rep;
  logic        cnt_to_flush;  // WR_CNT was entered on the way to FLUSH
`endif

  // Every write state consumes exactly one word.
  always_comb begin
    ptr_inc_en = (state == ST_WR_SRC) || (state == ST_WR_DST);
`ifdef CFLOG_LOOP_COMPRESS_EN
    if (state == ST_WR_CNT) ptr_inc_en = 1'b1;
`endif
  end
  assign ptr_clr = (state == ST_FLUSH) && bus.flush_ack;

  cflog_ptr #(.LOG_MIN(LOG_MIN), .LOG_SIZE(LOG_SIZE), .ENTRY(ENTRY_SZ)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (ptr_inc_en),
    .clr      (ptr_clr),
    .ptr      (ptr),
    .addr_cur (addr_cur),
    .addr_inc (addr_inc),
    .free_low (free_low)
  );

  // Write strobe/address/data are loaded on the edge that enters a write
  // state, so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      flush_req_q <= 1'b0;
      stall_q     <= 1'b0;
      ovf_q       <= 1'b0;
      pair_src    <= '0;
      pair_dst    <= '0;
`ifdef CFLOG_LOOP_COMPRESS_EN
      last_vld     <= 1'b0;
      rep          <= '0;
      cnt_to_flush <= 1'b0;
`endif
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      if (bus.branch_valid && state != ST_IDLE) ovf_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.branch_valid) begin
`ifdef CFLOG_LOOP_COMPRESS_EN
            if (last_vld && bus.branch_src == pair_src && bus.branch_dst == pair_dst) begin
              if (rep != 16'hFFFF) rep <= rep + 16'd1;
            end else begin
              pair_src  <= bus.branch_src;
              pair_dst  <= bus.branch_dst;
              last_vld  <= 1'b1;
              stall_q   <= 1'b1;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_cur;
              if (rep != 16'd0) begin
                state        <= ST_WR_CNT;
                cnt_to_flush <= 1'b0;
                wr_data_q    <= rep;
              end else begin
                state     <= ST_WR_SRC;
                wr_data_q <= bus.branch_src;
              end
            end
`else
            pair_src  <= bus.branch_src;
            pair_dst  <= bus.branch_dst;
            state     <= ST_WR_SRC;
            stall_q   <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_cur;
            wr_data_q <= bus.branch_src;
`endif
          end else if (bus.flush_now && ptr != 16'd0) begin
`ifdef CFLOG_LOOP_COMPRESS_EN
            if (rep != 16'd0) begin
              state        <= ST_WR_CNT;
              cnt_to_flush <= 1'b1;
              stall_q      <= 1'b1;
              wr_en_q      <= 1'b1;
              wr_addr_q    <= addr_cur;
              wr_data_q    <= rep;
            end else
`endif
            begin
              state       <= ST_FLUSH;
              flush_req_q <= 1'b1;
              stall_q     <= 1'b1;
            end
          end
        end

        ST_WR_SRC: begin
          state     <= ST_WR_DST;
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_inc;
          wr_data_q <= pair_dst;
        end

        ST_WR_DST: begin
          if (free_low) begin
            state       <= ST_FLUSH;
            flush_req_q <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            stall_q <= 1'b0;
          end
        end

`ifdef CFLOG_LOOP_COMPRESS_EN
        ST_WR_CNT: begin
          rep <= '0;
          if (cnt_to_flush) begin
            state       <= ST_FLUSH;
            flush_req_q <= 1'b1;
          end else begin
            state     <= ST_WR_SRC;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_inc;
            wr_data_q <= pair_src;
          end
        end
`endif

        ST_FLUSH: begin
          if (bus.flush_ack) begin
            state       <= ST_IDLE;
            flush_req_q <= 1'b0;
            stall_q     <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
            last_vld    <= 1'b0;  // first event after a flush is always logged
`endif
          end
        end

        default: begin
          state       <= ST_IDLE;
          flush_req_q <= 1'b0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.log_wr_en   = wr_en_q;
  assign bus.log_wr_addr = wr_addr_q;
  assign bus.log_wr_data = wr_data_q;
  assign bus.log_ptr     = ptr;
  assign bus.flush_req   = flush_req_q;
  assign bus.cpu_stall   = stall_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_cflog_writer.sv
// tb_cflog_writer: table-driven directed vectors, hand sequences for fill,
// reset and loop compression, and random traffic against a queue-based
// reference model of the log writer.
module tb_cflog_writer;

  localparam logic [15:0] LMIN  = 16'h01B0;
  localparam int          LSIZE = 128;
`ifdef CFLOG_LOOP_COMPRESS_EN
  localparam int ENTRY = 3;
`else
  localparam int ENTRY = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  cflog_writer_if bus();

  cflog_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        bv;
    logic [15:0] src;
    logic [15:0] dst;
    logic        fn;
    logic        ack;
    logic [51:0] exp;
  } vec_t;

  function automatic logic [51:0] mk(input logic we, input logic [15:0] a, d, p,
                                     input logic fr, st, ov);
    return {we, a, d, p, fr, st, ov};
  endfunction

  function automatic logic [51:0] outs();
    return {bus.log_wr_en, bus.log_wr_addr, bus.log_wr_data, bus.log_ptr,
            bus.flush_req, bus.cpu_stall, bus.overflow};
  endfunction

  function automatic vec_t vec(input logic bv, input logic [15:0] s, d,
                               input logic fn, ack, input logic [51:0] e);
    vec_t v;
    v.bv = bv; v.src = s; v.dst = d; v.fn = fn; v.ack = ack; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic bv, input logic [15:0] s, d, input logic fn, ack);
    bus.branch_valid = bv;
    bus.branch_src   = s;
    bus.branch_dst   = d;
    bus.flush_now    = fn;
    bus.flush_ack    = ack;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = accepting events, 1 = words queued for writing, 2 = handed to TCB
  int          m_mode;
  int          m_ptr;
  logic        m_ovf;
  logic [15:0] m_wq[$];
  logic        m_lv, m_flush_after;
  logic [15:0] m_ls, m_ld;
  int          m_rep;

  function automatic void model_init();
    m_mode = 0; m_ptr = 0; m_ovf = 0; m_wq.delete();
    m_lv = 0; m_flush_after = 0; m_ls = 0; m_ld = 0; m_rep = 0;
  endfunction

  function automatic void model_step(input logic bv, input logic [15:0] s, d,
                                     input logic fn, ack);
    if (m_mode != 0 && bv) m_ovf = 1;
    case (m_mode)
      0: begin
        if (bv) begin
`ifdef CFLOG_LOOP_COMPRESS_EN
          if (m_lv && s == m_ls && d == m_ld) begin
            if (m_rep < 65535) m_rep++;
          end else begin
            if (m_rep != 0) m_wq.push_back(16'(m_rep));
            m_rep = 0;
            m_wq.push_back(s);
            m_wq.push_back(d);
            m_ls = s; m_ld = d; m_lv = 1;
            m_flush_after = 0;
            m_mode = 1;
          end
`else
          m_wq.push_back(s);
          m_wq.push_back(d);
          m_mode = 1;
`endif
        end else if (fn && m_ptr != 0) begin
          if (m_rep != 0) begin
            m_wq.push_back(16'(m_rep));
            m_rep = 0;
            m_flush_after = 1;
            m_mode = 1;
          end else begin
            m_mode = 2;
          end
        end
      end
      1: begin
        m_ptr++;
        void'(m_wq.pop_front());
        if (m_wq.size() == 0) begin
          if (m_flush_after || (LSIZE - m_ptr) < ENTRY) m_mode = 2;
          else m_mode = 0;
          m_flush_after = 0;
        end
      end
      default: begin
        if (ack) begin
          m_ptr = 0;
          m_mode = 0;
          m_lv = 0;
        end
      end
    endcase
  endfunction

  function automatic logic [51:0] model_exp();
    logic [15:0] a, dd;
    a  = (m_mode == 1) ? 16'(LMIN + 16'(2 * m_ptr)) : 16'h0;
    dd = (m_mode == 1) ? m_wq[0] : 16'h0;
    return mk(m_mode == 1, a, dd, 16'(m_ptr), m_mode == 2, m_mode != 0, m_ovf);
  endfunction

  // ---------------- test ----------------
  vec_t        tbl[15];
  logic [15:0] last_addr;
  logic [31:0] got[$];
  logic [31:0] exp_w[5];

  initial begin
    int ev;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("reset_state", outs(), 0);
    reset = 1'b0;

    // directed vectors: inputs before the edge, outputs after it
    tbl[0]  = vec(1, 16'hE010, 16'hE200, 0, 0, mk(1, 16'h01B0, 16'hE010, 0, 0, 1, 0));
    tbl[1]  = vec(0, 0, 0, 0, 0,               mk(1, 16'h01B2, 16'hE200, 1, 0, 1, 0));
    tbl[2]  = vec(0, 0, 0, 0, 0,               mk(0, 0, 0, 2, 0, 0, 0));
    tbl[3]  = vec(1, 16'hE300, 16'hE302, 0, 0, mk(1, 16'h01B4, 16'hE300, 2, 0, 1, 0));
    tbl[4]  = vec(1, 16'hE310, 16'hE312, 0, 0, mk(1, 16'h01B6, 16'hE302, 3, 0, 1, 1));
    tbl[5]  = vec(0, 0, 0, 1, 0,               mk(0, 0, 0, 4, 0, 0, 1));
    tbl[6]  = vec(0, 0, 0, 1, 0,               mk(0, 0, 0, 4, 1, 1, 1));
    tbl[7]  = vec(0, 0, 0, 0, 0,               mk(0, 0, 0, 4, 1, 1, 1));
    tbl[8]  = vec(0, 0, 0, 0, 1,               mk(0, 0, 0, 0, 0, 0, 1));
    tbl[9]  = vec(0, 0, 0, 1, 0,               mk(0, 0, 0, 0, 0, 0, 1));
    tbl[10] = vec(1, 16'hE400, 16'hE402, 1, 0, mk(1, 16'h01B0, 16'hE400, 0, 0, 1, 1));
    tbl[11] = vec(0, 0, 0, 1, 0,               mk(1, 16'h01B2, 16'hE402, 1, 0, 1, 1));
    tbl[12] = vec(0, 0, 0, 1, 0,               mk(0, 0, 0, 2, 0, 0, 1));
    tbl[13] = vec(0, 0, 0, 1, 0,               mk(0, 0, 0, 2, 1, 1, 1));
    tbl[14] = vec(0, 0, 0, 0, 1,               mk(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].bv, tbl[i].src, tbl[i].dst, tbl[i].fn, tbl[i].ack);
      cyc();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // fill the log until it hands off to the TCB
    do_reset();
    ev = LSIZE / 2;
    if (ENTRY == 3) ev = (LSIZE - 2) / 2;
    last_addr = 0;
    for (int i = 0; i < ev; i++) begin
      drive(1, 16'(16'hD000 + 4 * i), 16'(16'hD002 + 4 * i), 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0);
      cyc();
      last_addr = bus.log_wr_addr;
      cyc();
    end
    chk("fill_last_addr", last_addr, 16'(LMIN + 2 * (2 * ev - 1)));
    chk("fill_ptr", bus.log_ptr, 16'(2 * ev));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("fill_hold%0d", k), {bus.flush_req, bus.cpu_stall}, 2'b11);
      cyc();
    end
    drive(0, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("fill_ack", {bus.flush_req, bus.cpu_stall, bus.log_ptr}, 0);

    // reset in WR_DST
    do_reset();
    drive(1, 16'hE010, 16'hE200, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("rst_pre_dst", {bus.log_wr_en, bus.log_wr_data}, {1'b1, 16'hE200});
    reset = 1'b1;
    cyc();
    chk("rst_in_dst", outs(), 0);
    reset = 1'b0;
    cyc();
    chk("rst_after_dst", outs(), 0);

    // reset in FLUSH
    drive(1, 16'hE020, 16'hE220, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    repeat (2) cyc();
    drive(0, 0, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("rst_pre_flush", {bus.flush_req, bus.log_ptr}, {1'b1, 16'd2});
    reset = 1'b1;
    cyc();
    chk("rst_in_flush", outs(), 0);
    reset = 1'b0;
    cyc();
    chk("rst_after_flush", outs(), 0);

`ifdef CFLOG_LOOP_COMPRESS_EN
    do_reset();
    got.delete();
    drive(1, 16'hE050, 16'hE040, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.log_wr_en) got.push_back({bus.log_wr_addr, bus.log_wr_data});
      drive(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'hE050, 16'hE040, 0, 0);
      cyc();
      chk($sformatf("cmp_rep%0d", i), {bus.cpu_stall, bus.log_wr_en}, 2'b00);
    end
    drive(1, 16'hE060, 16'hE100, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.log_wr_en) got.push_back({bus.log_wr_addr, bus.log_wr_data});
      drive(0, 0, 0, 0, 0);
    end
    exp_w[0] = {16'h01B0, 16'hE050};
    exp_w[1] = {16'h01B2, 16'hE040};
    exp_w[2] = {16'h01B4, 16'h0004};
    exp_w[3] = {16'h01B6, 16'hE060};
    exp_w[4] = {16'h01B8, 16'hE100};
    chk("cmp_nwr", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("cmp_w%0d", i), (i < got.size()) ? got[i] : 32'hX, exp_w[i]);
    chk("cmp_ptr", bus.log_ptr, 16'd5);
`endif

    // random traffic vs reference model
    do_reset();
    model_init();
    for (int c = 0; c < 3000; c++) begin
      logic        bv, fn, ack;
      logic [15:0] s, d;
      bv  = ($urandom_range(0, 2) == 0);
      s   = 16'(16'hE000 + 4 * $urandom_range(0, 2));
      d   = 16'(16'hE800 + 2 * $urandom_range(0, 1));
      fn  = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 3) == 0);
      drive(bv, s, d, fn, ack);
      @(posedge clk);
      model_step(bv, s, d, fn, ack);
      #1;
      chk($sformatf("rand%0d", c), outs(), model_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
